apb4_slave_regfile: RTL and testbench
=====================================

Name: apb4_slave_regfile

Overview:
- APB4 completer for the APB4 master block: decodes one APB4 transfer at a time and services it from a bank of NUM_REGS x DATA_WIDTH registers.
- Provides configurable wait states, PSTRB byte-lane writes and PSLVERR signalling.
- Sits behind the APB select/decoder path. Its PREADY/PRDATA/PSLVERR feed the master's *_DECODER inputs.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8.
- ADDR_WIDTH, 32, address bus width.
- NUM_REGS, 16, number of word registers; 2..2^(ADDR_WIDTH-3).
- WAIT_STATES, 0, access cycles with PREADY low before PREADY high; 0..15.
- ID_VALUE, 32'hA5B4_0001, constant returned by register 0, which is read-only.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset. One clock; reset is synchronous and active-high.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PADDR  in  ADDR_WIDTH  byte address; bit ADDR_WIDTH-1 is the select bit and is ignored by decode.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PREADY  out  1  transfer completes this cycle; registered.
- PRDATA  out  DATA_WIDTH  read data; registered.
- PSLVERR  out  1  transfer error; registered, valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1 at an edge):
  - state=IDLE; PREADY=0, PRDATA=0, PSLVERR=0.
  - Registers 1..NUM_REGS-1 = 0; register 0 reads ID_VALUE.
  - Any in-flight transfer is dropped with no write.
- Decode:
  - idx = PADDR[ADDR_WIDTH-2:2].
  - Error if any of: PADDR[1:0] != 0; idx >= NUM_REGS; (PWRITE=1 and idx == 0).
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - At an edge with PSEL=1 & PENABLE=0 (setup), latch addr, write, wdata, strb and error.
  - If WAIT_STATES=0: go to READY and load PREADY=1, PSLVERR=err, PRDATA = (read & !err) ? reg[idx] : 0.
  - Else: go to WAIT with cnt=WAIT_STATES.
- WAIT:
  - PREADY=0. Each edge with PSEL=1 & PENABLE=1: cnt-=1.
  - When cnt==1: go to READY, loading PREADY, PSLVERR and PRDATA as above.
  - Result: exactly WAIT_STATES access cycles with PREADY=0.
- READY:
  - This cycle completes the transfer.
  - At the edge: if write & !err, reg[idx] byte k <= PWDATA_latched byte k for each PSTRB_latched[k]=1.
  - Then go to IDLE with PREADY=0, PSLVERR=0, PRDATA=0.
- Latency: first access cycle for WAIT_STATES=0. Back-to-back transfers (setup immediately after READY) are accepted from IDLE with no bubble.
- Latched values: address, data and strobes are captured at the setup edge; later bus changes during WAIT are ignored.
- Strobes:
  - PSTRB=0 on a write: no register change, no error.
  - PSTRB is ignored on reads.
- Error transfers:
  - No register update; PRDATA=0; PSLVERR=1 only in the READY cycle.
  - Wait states are still inserted.
- Abort: PSEL=0 while in WAIT or READY → IDLE next edge, outputs cleared, no write.
- PENABLE=1 in IDLE without a prior setup is ignored; PREADY stays 0.
- Read-after-write to the same register returns the new value on the next transfer.

Test Plan:
1. Reset, then WAIT_STATES=0, write 0x8000_0004 data 0xDEAD_BEEF strb 4'hF, then read 0x8000_0004 → PREADY=1 in first access cycle of each; read PRDATA=0xDEAD_BEEF, PSLVERR=0.
2. Byte strobes: reg1=0xDEAD_BEEF, write 0x1122_3344 strb 4'b0101 → read returns 0xDE22_BE44.
3. WAIT_STATES=3, read 0x8000_0000 → PREADY low for 3 access cycles, high on 4th with PRDATA=0xA5B4_0001.
4. Errors, each with PSLVERR=1 in the completion cycle and register contents unchanged:
   - write to reg0;
   - read 0x8000_0002 (misaligned);
   - read idx 16 with NUM_REGS=16 → PRDATA=0.
5. Back-to-back write reg2=0x0000_0055 then read reg2 with no IDLE cycle → both complete; read returns 0x0000_0055.
6. Assert PRESET during a WAIT_STATES=2 write to reg3 → PREADY stays 0, reg3 reads 0 after reset; PRDATA/PSLVERR = 0.

Source files
------------

// File: rtl/apb4_slave_regfile.sv
// APB4 completer backed by a NUM_REGS x DATA_WIDTH register bank.
// It supports programmable wait states, byte-strobed writes, and a read-only ID register at index 0.
module apb4_slave_regfile #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B4_0001
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam int                    IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [3:0]            WS_INIT    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  setup, access;
    logic [ADDR_WIDTH-1:0] bus_word;
    logic [IDX_W-1:0]      bus_idx;
    logic                  bus_err;
    logic                  cur_wr, cur_err;
    logic [IDX_W-1:0]      cur_idx;
    logic                  unused_sel;

    assign setup      = PSEL & ~PENABLE;
    assign access     = PSEL & PENABLE;
    assign bus_word   = {3'b000, PADDR[ADDR_WIDTH-2:2]};
    assign bus_idx    = PADDR[IDX_W+1:2];
    assign bus_err    = (PADDR[1:0] != 2'b00) || (bus_word >= NUM_REGS_A) ||
                        (PWRITE && (bus_word == '0));
    assign unused_sel = PADDR[ADDR_WIDTH-1];

    // With no wait states, the completion is loaded at the setup edge, so decode comes from the live bus.
    assign cur_wr  = (state_q == S_IDLE) ? PWRITE  : wr_q;
    assign cur_err = (state_q == S_IDLE) ? bus_err : err_q;
    assign cur_idx = (state_q == S_IDLE) ? bus_idx : idx_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == 0) ? ID_VALUE : '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup)
                    state_d = (WAIT_STATES == 0) ? S_READY : S_WAIT;
            end
            S_WAIT: begin
                if (!PSEL)
                    state_d = S_IDLE;
                else if (PENABLE && cnt_q == 4'd1)
                    state_d = S_READY;
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        regs_d    = regs_q;

        if (state_q == S_IDLE && setup) begin
            idx_d   = bus_idx;
            wr_d    = PWRITE;
            err_d   = bus_err;
            wdata_d = PWDATA;
            strb_d  = PSTRB;
            cnt_d   = WS_INIT;
        end

        if (state_q == S_WAIT && access)
            cnt_d = cnt_q - 4'd1;

        if (state_d == S_READY) begin
            pready_d  = 1'b1;
            pslverr_d = cur_err;
            if (!cur_wr && !cur_err)
                prdata_d = regs_q[cur_idx];
        end

        // The commit needs PSEL in the completion cycle; an abort here writes nothing.
        if (state_q == S_READY && access && wr_q && !err_q) begin
            for (int k = 0; k < STRB_W; k++)
                if (strb_q[k])
                    regs_d[idx_q][8*k +: 8] = wdata_q[8*k +: 8];
        end

        regs_d[0] = ID_VALUE;
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Bench for apb4_slave_regfile. It runs three instances (0, 2 and 3 wait states) against a word-array reference model.
module tb_apb4_slave_regfile;

    localparam logic [31:0] ID = 32'hA5B4_0001;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [2:0]       psel;
    logic             PENABLE;
    logic             PWRITE;
    logic [31:0]      PADDR;
    logic [31:0]      PWDATA;
    logic [3:0]       PSTRB;
    logic [2:0]       pready;
    logic [2:0]       pslverr;
    logic [2:0][31:0] prdata;

    logic [31:0] mem [3][16];
    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb4_slave_regfile #(.WAIT_STATES(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb4_slave_regfile #(.WAIT_STATES(2)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    apb4_slave_regfile #(.WAIT_STATES(3)) u_dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ws(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    function automatic logic [31:0] mread(input int k, input int idx);
        return (idx == 0) ? ID : mem[k][idx];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                mem[k][i] = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // One complete transfer. The task is entered and left at 1 time unit after a rising edge.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input string tag, output logic [31:0] rd);
        int   idx;
        bit   err;
        bit   got;
        int   waits;
        logic [31:0] exp_rd;
        idx    = int'(addr[30:2]);
        err    = (addr[1:0] != 2'b00) || (idx >= 16) || (wr && idx == 0);
        exp_rd = (!wr && !err) ? mread(k, idx) : 32'h0;

        psel[k] = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        // Scramble the bus after setup. The transfer must use the values captured at setup.
        PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom); PWRITE = 1'($urandom);
        got = 0; waits = 0; rd = '0;
        while (!got && waits <= 40) begin
            @(negedge PCLK);
            if (pready[k]) begin
                got = 1;
            end else begin
                check({tag, ".wait_slverr"}, 32'(pslverr[k]), 32'h0);
                waits++;
                @(posedge PCLK);
                #1;
            end
        end
        if (!got) begin
            check({tag, ".timeout"}, 32'h0, 32'h1);
        end else begin
            rd = prdata[k];
            check({tag, ".waits"}, 32'(waits), 32'(ws(k)));
            check({tag, ".slverr"}, 32'(pslverr[k]), 32'(err));
            check({tag, ".rdata"}, rd, exp_rd);
            if (wr && !err)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        @(posedge PCLK);
        #1;
        psel[k] = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          sel;
        PRESET = 1'b1; psel = '0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        model_reset();
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        for (int k = 0; k < 3; k++) begin
            check("rst.pready", 32'(pready[k]), 32'h0);
            check("rst.prdata", prdata[k], 32'h0);
            check("rst.pslverr", 32'(pslverr[k]), 32'h0);
        end
        @(posedge PCLK);
        #1;

        // Write, then read back with no wait states.
        xfer(0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, "t1.wr", rd);
        xfer(0, 0, 32'h8000_0004, 32'h0, 4'h0, "t1.rd", rd);
        check("t1.value", rd, 32'hDEAD_BEEF);

        // Partial write through byte strobes.
        xfer(0, 1, 32'h8000_0004, 32'h1122_3344, 4'b0101, "t2.wr", rd);
        xfer(0, 0, 32'h8000_0004, 32'h0, 4'h0, "t2.rd", rd);
        check("t2.value", rd, 32'hDE22_BE44);

        // Read the ID register through the instance with 3 wait states.
        idle(1);
        xfer(2, 0, 32'h8000_0000, 32'h0, 4'h0, "t3.id", rd);
        check("t3.value", rd, ID);

        // Error cases. A follow-up read confirms that register 1 is unchanged.
        xfer(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, "t4.wr0", rd);
        xfer(0, 0, 32'h8000_0002, 32'h0, 4'h0, "t4.misal", rd);
        xfer(0, 0, 32'h8000_0040, 32'h0, 4'h0, "t4.oor", rd);
        check("t4.oor_rdata", rd, 32'h0);
        xfer(0, 1, 32'h8000_0005, 32'h0BAD_0BAD, 4'hF, "t4.misal_wr", rd);
        xfer(0, 0, 32'h8000_0004, 32'h0, 4'h0, "t4.reg1", rd);
        check("t4.reg1_value", rd, 32'hDE22_BE44);
        xfer(0, 0, 32'h8000_0000, 32'h0, 4'h0, "t4.id", rd);
        check("t4.id_value", rd, ID);

        // Back-to-back write then read with no idle cycle between them.
        xfer(0, 1, 32'h8000_0008, 32'h0000_0055, 4'hF, "t5.wr", rd);
        xfer(0, 0, 32'h8000_0008, 32'h0, 4'h0, "t5.rd", rd);
        check("t5.value", rd, 32'h0000_0055);

        // PENABLE without a setup phase must not start a transfer.
        psel[0] = 1'b1; PENABLE = 1'b1; PADDR = 32'h8000_0004; PWRITE = 1'b0;
        repeat (2) begin
            @(negedge PCLK);
            check("noset.pready", 32'(pready[0]), 32'h0);
            @(posedge PCLK);
            #1;
        end
        psel[0] = 1'b0; PENABLE = 1'b0;
        idle(1);

        // Abort during WAIT: dropping PSEL must discard the write.
        psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h8000_0014; PWDATA = 32'h1234_5678; PSTRB = 4'hF;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        psel[2] = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("abort.pready", 32'(pready[2]), 32'h0);
        @(posedge PCLK);
        #1;
        xfer(2, 0, 32'h8000_0014, 32'h0, 4'h0, "abort.rd", rd);
        check("abort.value", rd, 32'h0);

        // Reset in the middle of a write to reg3 on the instance with 2 wait states.
        xfer(1, 1, 32'h8000_000C, 32'hCAFE_F00D, 4'hF, "t6.pre", rd);
        psel[1] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h8000_000C; PWDATA = 32'h7777_7777; PSTRB = 4'hF;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("t6.wait_pready", 32'(pready[1]), 32'h0);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0; psel[1] = 1'b0; PENABLE = 1'b0;
        model_reset();
        @(negedge PCLK);
        check("t6.pready", 32'(pready[1]), 32'h0);
        check("t6.prdata", prdata[1], 32'h0);
        check("t6.pslverr", 32'(pslverr[1]), 32'h0);
        @(posedge PCLK);
        #1;
        xfer(1, 0, 32'h8000_000C, 32'h0, 4'h0, "t6.rd", rd);
        check("t6.value", rd, 32'h0);

        // Randomized traffic on all three instances.
        for (int n = 0; n < 150; n++) begin
            int k;
            k   = int'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)
                a = {1'($urandom), 29'($urandom_range(0, 15)), 2'b00};
            else if (sel == 7)
                a = {1'($urandom), 29'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            else
                a = {1'($urandom), 29'($urandom_range(16, 40)), 2'b00};
            xfer(k, 1'($urandom), a, $urandom, 4'($urandom), "rand", rd);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
